// File: rtl/warp_scheduler.sv
// warp_scheduler: splits a dispatched block into warps, issues them round-robin
// over a valid/ready handshake, re-queues yielded warps, counts retirements and
// pulses core_done once the whole block has retired.
module warp_scheduler #(
  parameter int MAX_WARPS = 8,
  parameter int WARP_SIZE = 32,
  parameter int WID_W     = $clog2(MAX_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          block_id,
  input  logic [31:0]          block_dim,
  input  logic [31:0]          num_threads,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [WID_W-1:0]     issue_warp_id,
  output logic [31:0]          issue_thread_base,
  output logic [WARP_SIZE-1:0] issue_mask,
  input  logic                 yield_valid,
  input  logic [WID_W-1:0]     yield_id,
  input  logic                 retire_valid,
  input  logic [WID_W-1:0]     retire_id,
  output logic                 core_done,
  output logic                 cfg_error
);

  localparam logic [31:0] WS_32 = 32'(WARP_SIZE);
  localparam logic [31:0] MW_32 = 32'(MAX_WARPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ISSUE,
    S_DONE,
    S_WAIT_LOW
  } state_t;

  state_t state_q, state_n;

  // Latched block parameters
  logic [31:0] blk_id_q, blk_dim_q, nthr_q;

  // Per-block geometry, captured at the end of SETUP
  logic [31:0]    base_q, tib_q;
  logic [WID_W:0] nw_q;

  // Warp bookkeeping
  logic [MAX_WARPS-1:0] ready_q, inflight_q;
  logic [WID_W:0]       ret_cnt_q;
  logic [WID_W-1:0]     rr_q;

  // Registered issue payload
  logic                 issue_valid_q;
  logic [WID_W-1:0]     issue_warp_id_q;
  logic [31:0]          issue_base_q;
  logic [WARP_SIZE-1:0] issue_mask_q;
  logic                 cfg_error_q;

  // Combinational helpers
  logic [31:0]          base_c, rem_c, tib_c, nw_c;
  logic [31:0]          base_n, tib_n;
  logic                 accept, yield_hit, retire_hit, blk_done;
  logic [MAX_WARPS-1:0] ready_n, inflight_n;
  logic [WID_W-1:0]     rr_n;
  logic [WID_W:0]       ret_cnt_n;
  logic                 sel_found;
  logic [WID_W-1:0]     sel_id;
  logic [WID_W-1:0]     scan_idx;
  logic [31:0]          sel_off, sel_lanes, sel_base;
  logic [WARP_SIZE-1:0] sel_mask;

  // Block geometry from the latched parameters (32-bit wrapping arithmetic)
  always_comb begin
    base_c = blk_id_q * blk_dim_q;
    rem_c  = (nthr_q > base_c) ? (nthr_q - base_c) : '0;
    tib_c  = (blk_dim_q < rem_c) ? blk_dim_q : rem_c;
    nw_c   = (tib_c / WS_32) + (((tib_c % WS_32) != '0) ? 32'd1 : 32'd0);
  end

  // Next-cycle warp bitmaps, round-robin pointer and retire count
  always_comb begin
    accept     = issue_valid_q & issue_ready;
    retire_hit = (state_q == S_ISSUE) && retire_valid && inflight_q[retire_id];
    // Retire takes priority when the same warp also yields this cycle
    yield_hit  = (state_q == S_ISSUE) && yield_valid && inflight_q[yield_id] &&
                 !(retire_hit && (retire_id == yield_id));
    ready_n    = ready_q;
    inflight_n = inflight_q;
    rr_n       = rr_q;
    ret_cnt_n  = ret_cnt_q;
    if (state_q == S_SETUP) begin
      inflight_n = '0;
      rr_n       = '0;
      ret_cnt_n  = '0;
      for (int unsigned i = 0; i < MAX_WARPS; i++) begin
        ready_n[i] = (nw_c <= MW_32) && (i < nw_c);
      end
    end else if (state_q == S_ISSUE) begin
      if (accept) begin
        ready_n[issue_warp_id_q]    = 1'b0;
        inflight_n[issue_warp_id_q] = 1'b1;
        rr_n                        = issue_warp_id_q + WID_W'(1);
      end
      if (yield_hit) begin
        inflight_n[yield_id] = 1'b0;
        ready_n[yield_id]    = 1'b1;
      end
      if (retire_hit) begin
        inflight_n[retire_id] = 1'b0;
        ret_cnt_n             = ret_cnt_q + (WID_W+1)'(1);
      end
    end
    blk_done = (state_q == S_ISSUE) && (ret_cnt_n == nw_q);
  end

  // Pick the next warp to offer from the next-cycle ready set, and build its payload
  always_comb begin
    base_n    = (state_q == S_SETUP) ? base_c : base_q;
    tib_n     = (state_q == S_SETUP) ? tib_c  : tib_q;
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < MAX_WARPS; i++) begin
      scan_idx = rr_n + i[WID_W-1:0];
      if (!sel_found && ready_n[scan_idx]) begin
        sel_found = 1'b1;
        sel_id    = scan_idx;
      end
    end
    sel_off   = 32'(sel_id) * WS_32;
    sel_base  = base_n + sel_off;
    sel_lanes = tib_n - sel_off;
    sel_mask  = '0;
    for (int unsigned k = 0; k < WARP_SIZE; k++) begin
      sel_mask[k] = (k < sel_lanes);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:     if (start) state_n = S_SETUP;
      S_SETUP:    state_n = ((nw_c > MW_32) || (nw_c == '0)) ? S_DONE : S_ISSUE;
      S_ISSUE:    if (blk_done) state_n = S_DONE;
      S_DONE:     state_n = S_WAIT_LOW;
      S_WAIT_LOW: if (!start) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    core_done = (state_q == S_DONE);
  end

  // Datapath registers: block latch, geometry, bitmaps and the issue payload
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_id_q        <= '0;
      blk_dim_q       <= '0;
      nthr_q          <= '0;
      base_q          <= '0;
      tib_q           <= '0;
      nw_q            <= '0;
      ready_q         <= '0;
      inflight_q      <= '0;
      ret_cnt_q       <= '0;
      rr_q            <= '0;
      issue_valid_q   <= 1'b0;
      issue_warp_id_q <= '0;
      issue_base_q    <= '0;
      issue_mask_q    <= '0;
      cfg_error_q     <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && start) begin
        blk_id_q  <= block_id;
        blk_dim_q <= block_dim;
        nthr_q    <= num_threads;
      end
      if (state_q == S_SETUP) begin
        base_q <= base_c;
        tib_q  <= tib_c;
        nw_q   <= nw_c[WID_W:0];
        if (nw_c > MW_32) cfg_error_q <= 1'b1;
      end
      ready_q    <= ready_n;
      inflight_q <= inflight_n;
      ret_cnt_q  <= ret_cnt_n;
      rr_q       <= rr_n;
      // The offer is reloaded only when idle or just accepted, so it never
      // changes under an un-accepted handshake.
      if (state_n == S_ISSUE) begin
        if (!issue_valid_q || accept) begin
          issue_valid_q   <= sel_found;
          issue_warp_id_q <= sel_id;
          issue_base_q    <= sel_base;
          issue_mask_q    <= sel_mask;
        end
      end else begin
        issue_valid_q   <= 1'b0;
        issue_warp_id_q <= '0;
        issue_base_q    <= '0;
        issue_mask_q    <= '0;
      end
    end
  end

  assign issue_valid       = issue_valid_q;
  assign issue_warp_id     = issue_warp_id_q;
  assign issue_thread_base = issue_base_q;
  assign issue_mask        = issue_mask_q;
  assign cfg_error         = cfg_error_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: scenario tasks with a scoreboard of expected warp offers.
module tb_warp_scheduler;

  localparam int MAX_WARPS = 8;
  localparam int WARP_SIZE = 32;
  localparam int WID_W     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start;
  logic [31:0]          block_id, block_dim, num_threads;
  logic                 issue_valid, issue_ready;
  logic [WID_W-1:0]     issue_warp_id;
  logic [31:0]          issue_thread_base;
  logic [WARP_SIZE-1:0] issue_mask;
  logic                 yield_valid, retire_valid;
  logic [WID_W-1:0]     yield_id, retire_id;
  logic                 core_done, cfg_error;

  typedef struct {
    logic [WID_W-1:0]     id;
    logic [31:0]          base;
    logic [WARP_SIZE-1:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  warp_scheduler #(.MAX_WARPS(MAX_WARPS), .WARP_SIZE(WARP_SIZE)) dut (
    .clk(clk), .rst(rst), .start(start),
    .block_id(block_id), .block_dim(block_dim), .num_threads(num_threads),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_warp_id(issue_warp_id), .issue_thread_base(issue_thread_base),
    .issue_mask(issue_mask),
    .yield_valid(yield_valid), .yield_id(yield_id),
    .retire_valid(retire_valid), .retire_id(retire_id),
    .core_done(core_done), .cfg_error(cfg_error)
  );

  function automatic void push_exp(int unsigned id, logic [31:0] base, logic [31:0] mask);
    exp_t e;
    e.id   = id[WID_W-1:0];
    e.base = base;
    e.mask = mask;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || core_done !== 1'b0 || cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b done=%b err=%b, expected 0 0 0", issue_valid, core_done, cfg_error);
    end
    checks++;
    if (issue_warp_id !== '0 || issue_thread_base !== '0 || issue_mask !== '0) begin
      errors++;
      $display("FAIL reset_payload: got id=%0d base=%0d mask=%h, expected 0", issue_warp_id, issue_thread_base, issue_mask);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_block();
    push_exp(0, 128, 32'hFFFF_FFFF);
    push_exp(1, 160, 32'hFFFF_FFFF);
    @(negedge clk);
    block_id = 2; block_dim = 64; num_threads = 256; issue_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      checks++;
      if (issue_valid !== (cyc == 2 || cyc == 3)) begin
        errors++;
        $display("FAIL full_valid cyc%0d: got %b expected %b", cyc, issue_valid, (cyc == 2 || cyc == 3));
      end
      checks++;
      if (core_done !== (cyc == 6)) begin
        errors++;
        $display("FAIL full_done cyc%0d: got %b expected %b", cyc, core_done, (cyc == 6));
      end
      if (issue_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL full_unexpected_issue: got id=%0d, expected none", issue_warp_id);
        end else if (issue_warp_id !== sb[0].id || issue_thread_base !== sb[0].base || issue_mask !== sb[0].mask) begin
          errors++;
          $display("FAIL full_payload: got id=%0d base=%0d mask=%h expected id=%0d base=%0d mask=%h",
                   issue_warp_id, issue_thread_base, issue_mask, sb[0].id, sb[0].base, sb[0].mask);
        end
      end
      retire_valid = (cyc == 4 || cyc == 5);
      retire_id    = (cyc == 5) ? 3'd1 : 3'd0;
      if (cyc == 9) start = 1'b0;
      if (issue_valid && issue_ready && sb.size() != 0) void'(sb.pop_front());
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL full_sb_left: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_partial_tail();
    push_exp(0, 192, 32'h0000_00FF);
    @(negedge clk);
    block_id = 3; block_dim = 64; num_threads = 200; issue_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      checks++;
      if (issue_valid !== (cyc == 2)) begin
        errors++;
        $display("FAIL tail_valid cyc%0d: got %b expected %b", cyc, issue_valid, (cyc == 2));
      end
      checks++;
      if (core_done !== (cyc == 4)) begin
        errors++;
        $display("FAIL tail_done cyc%0d: got %b expected %b", cyc, core_done, (cyc == 4));
      end
      if (issue_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL tail_unexpected_issue: got id=%0d, expected none", issue_warp_id);
        end else if (issue_warp_id !== sb[0].id || issue_thread_base !== sb[0].base || issue_mask !== sb[0].mask) begin
          errors++;
          $display("FAIL tail_payload: got id=%0d base=%0d mask=%h expected id=%0d base=%0d mask=%h",
                   issue_warp_id, issue_thread_base, issue_mask, sb[0].id, sb[0].base, sb[0].mask);
        end
      end
      retire_valid = (cyc == 3);
      retire_id    = 3'd0;
      if (cyc == 4) start = 1'b0;
      if (issue_valid && issue_ready && sb.size() != 0) void'(sb.pop_front());
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL tail_sb_left: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    block_id = 4; block_dim = 64; num_threads = 200; issue_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL oor_valid cyc%0d: got %b expected 0", cyc, issue_valid);
      end
      checks++;
      if (core_done !== (cyc == 2)) begin
        errors++;
        $display("FAIL oor_done cyc%0d: got %b expected %b", cyc, core_done, (cyc == 2));
      end
      checks++;
      if (cfg_error !== 1'b0) begin
        errors++;
        $display("FAIL oor_cfg_error cyc%0d: got %b expected 0", cyc, cfg_error);
      end
      if (cyc == 2) start = 1'b0;
    end
  endtask

  task automatic test_yield_rr();
    push_exp(0,  0, 32'hFFFF_FFFF);
    push_exp(1, 32, 32'hFFFF_FFFF);
    push_exp(2, 64, 32'hFFFF_FFFF);
    push_exp(3, 96, 32'hFFFF_FFFF);
    push_exp(1, 32, 32'hFFFF_FFFF);
    @(negedge clk);
    block_id = 0; block_dim = 128; num_threads = 1000; issue_ready = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      checks++;
      if (issue_valid !== (cyc >= 2 && cyc <= 8)) begin
        errors++;
        $display("FAIL rr_valid cyc%0d: got %b expected %b", cyc, issue_valid, (cyc >= 2 && cyc <= 8));
      end
      checks++;
      if (core_done !== (cyc == 14)) begin
        errors++;
        $display("FAIL rr_done cyc%0d: got %b expected %b", cyc, core_done, (cyc == 14));
      end
      if (issue_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rr_unexpected_issue: got id=%0d, expected none", issue_warp_id);
        end else if (issue_warp_id !== sb[0].id || issue_thread_base !== sb[0].base || issue_mask !== sb[0].mask) begin
          errors++;
          $display("FAIL rr_payload cyc%0d: got id=%0d base=%0d mask=%h expected id=%0d base=%0d mask=%h",
                   cyc, issue_warp_id, issue_thread_base, issue_mask, sb[0].id, sb[0].base, sb[0].mask);
        end
      end
      issue_ready  = (cyc >= 4);
      yield_valid  = (cyc == 6 || cyc == 9);
      yield_id     = (cyc == 6) ? 3'd1 : 3'd0;
      retire_valid = (cyc >= 9 && cyc <= 13);
      case (cyc)
        11:      retire_id = 3'd1;
        12:      retire_id = 3'd2;
        13:      retire_id = 3'd3;
        default: retire_id = 3'd0;
      endcase
      if (cyc == 14) start = 1'b0;
      if (issue_valid && issue_ready && sb.size() != 0) void'(sb.pop_front());
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rr_sb_left: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_oversize();
    @(negedge clk);
    block_id = 0; block_dim = 300; num_threads = 1000; issue_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (issue_valid !== 1'b0) begin
        errors++;
        $display("FAIL over_valid cyc%0d: got %b expected 0", cyc, issue_valid);
      end
      checks++;
      if (core_done !== (cyc == 2)) begin
        errors++;
        $display("FAIL over_done cyc%0d: got %b expected %b", cyc, core_done, (cyc == 2));
      end
      checks++;
      if (cfg_error !== (cyc >= 2)) begin
        errors++;
        $display("FAIL over_cfg_error cyc%0d: got %b expected %b", cyc, cfg_error, (cyc >= 2));
      end
      if (cyc == 2) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_block();
    push_exp(0,  0, 32'hFFFF_FFFF);
    push_exp(1, 32, 32'hFFFF_FFFF);
    @(negedge clk);
    block_id = 0; block_dim = 64; num_threads = 1000; issue_ready = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      checks++;
      if (issue_valid !== (cyc == 2 || cyc == 3)) begin
        errors++;
        $display("FAIL rstmid_valid cyc%0d: got %b expected %b", cyc, issue_valid, (cyc == 2 || cyc == 3));
      end
      if (issue_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rstmid_unexpected_issue: got id=%0d, expected none", issue_warp_id);
        end else if (issue_warp_id !== sb[0].id || issue_thread_base !== sb[0].base || issue_mask !== sb[0].mask) begin
          errors++;
          $display("FAIL rstmid_payload: got id=%0d base=%0d mask=%h expected id=%0d base=%0d mask=%h",
                   issue_warp_id, issue_thread_base, issue_mask, sb[0].id, sb[0].base, sb[0].mask);
        end
      end
      if (cyc == 4) rst = 1'b1;
      if (issue_valid && issue_ready && sb.size() != 0) void'(sb.pop_front());
    end
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || core_done !== 1'b0 || cfg_error !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flags: got valid=%b done=%b err=%b, expected 0 0 0", issue_valid, core_done, cfg_error);
    end
    checks++;
    if (issue_warp_id !== '0 || issue_thread_base !== '0 || issue_mask !== '0) begin
      errors++;
      $display("FAIL rstmid_payload_clr: got id=%0d base=%0d mask=%h, expected 0", issue_warp_id, issue_thread_base, issue_mask);
    end
    rst = 1'b0; start = 1'b0; retire_valid = 1'b1; retire_id = 3'd0;
    @(negedge clk);
    retire_id = 3'd1;
    @(negedge clk);
    retire_valid = 1'b0;
    checks++;
    if (core_done !== 1'b0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stale: got done=%b valid=%b, expected 0 0", core_done, issue_valid);
    end
    // Fresh block: 36 threads -> full warp at 64, four-lane tail at 96
    push_exp(0, 64, 32'hFFFF_FFFF);
    push_exp(1, 96, 32'h0000_000F);
    block_id = 1; block_dim = 64; num_threads = 100; start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      checks++;
      if (issue_valid !== (cyc == 2 || cyc == 3)) begin
        errors++;
        $display("FAIL fresh_valid cyc%0d: got %b expected %b", cyc, issue_valid, (cyc == 2 || cyc == 3));
      end
      checks++;
      if (core_done !== (cyc == 6)) begin
        errors++;
        $display("FAIL fresh_done cyc%0d: got %b expected %b", cyc, core_done, (cyc == 6));
      end
      if (issue_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL fresh_unexpected_issue: got id=%0d, expected none", issue_warp_id);
        end else if (issue_warp_id !== sb[0].id || issue_thread_base !== sb[0].base || issue_mask !== sb[0].mask) begin
          errors++;
          $display("FAIL fresh_payload: got id=%0d base=%0d mask=%h expected id=%0d base=%0d mask=%h",
                   issue_warp_id, issue_thread_base, issue_mask, sb[0].id, sb[0].base, sb[0].mask);
        end
      end
      retire_valid = (cyc == 4 || cyc == 5);
      retire_id    = (cyc == 5) ? 3'd1 : 3'd0;
      if (cyc == 6) start = 1'b0;
      if (issue_valid && issue_ready && sb.size() != 0) void'(sb.pop_front());
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL fresh_sb_left: got %0d pending, expected 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    block_id = '0; block_dim = '0; num_threads = '0;
    issue_ready = 1'b0;
    yield_valid = 1'b0; yield_id = '0;
    retire_valid = 1'b0; retire_id = '0;
    test_reset();
    test_full_block();
    test_partial_tail();
    test_out_of_range();
    test_yield_rr();
    test_oversize();
    test_reset_mid_block();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
